// File: rtl/conv_frame_sequencer_if.sv
// Handshake and address bundle between the frame sequencer and its environment.
// slave modport : sequencer side (takes start/in_valid/filt_req, drives the rest).
// master modport: source/datapath side (drives start/in_valid/filt_req).
interface conv_frame_sequencer_if #(
  parameter int CW = 2
);
  logic          start;
  logic          in_valid;
  logic          in_ready;
  logic          wr_en;
  logic [CW-1:0] wr_row;
  logic [CW-1:0] wr_col;
  logic          calc_start;
  logic [CW-1:0] calc_row;
  logic [CW-1:0] calc_col;
  logic          out_valid;
  logic [CW-1:0] out_row;
  logic [CW-1:0] out_col;
  logic          frame_done;
  logic          busy;
  logic          filt_req;
  logic          filt_load;

  modport slave (
    input  start, in_valid, filt_req,
    output in_ready, wr_en, wr_row, wr_col,
    output calc_start, calc_row, calc_col,
    output out_valid, out_row, out_col,
    output frame_done, busy, filt_load
  );

  modport master (
    output start, in_valid, filt_req,
    input  in_ready, wr_en, wr_row, wr_col,
    input  calc_start, calc_row, calc_col,
    input  out_valid, out_row, out_col,
    input  frame_done, busy, filt_load
  );
endinterface

// File: rtl/conv_frame_sequencer.sv
// Sequences one square frame of pixels into the 3x3 conv datapath: raster write
// addresses, one window launch per pixel with row,col >= 2, result tracking.
// Latency: calc_start 1 cycle after the pixel, out_valid CALC_LAT cycles later.
// Backpressure: in_ready high only while loading; in_valid gaps hold the raster.
// Ports: clk, rst_n (async active-low), bus (conv_frame_sequencer_if.slave).
// Option: define CONV_SEQ_FILT_DEFER_EN to defer filt_req seen mid-frame until
// the frame ends; otherwise filt_req is honoured only in IDLE.
module conv_frame_sequencer #(
  parameter int IMG_SIZE = 3,
  parameter int CALC_LAT = 2
) (
  input  logic clk,
  input  logic rst_n,
  conv_frame_sequencer_if.slave bus
);
  localparam int CW = ($clog2(IMG_SIZE) < 1) ? 1 : $clog2(IMG_SIZE);
  localparam logic [CW-1:0] LAST     = CW'(IMG_SIZE - 1);
  localparam logic [CW-1:0] LAST_WIN = CW'(IMG_SIZE - 3);
  localparam logic [CW-1:0] TWO      = CW'(2);
  localparam logic [CW-1:0] ONE      = CW'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t        state;
  logic [CW-1:0] row;
  logic [CW-1:0] col;
  logic          calc_start_q;
  logic [CW-1:0] calc_row_q;
  logic [CW-1:0] calc_col_q;
  logic          filt_load_q;
  // Result tracker: one slot per datapath cycle, oldest at CALC_LAT-1.
  logic          pipe_vld [CALC_LAT];
  logic [CW-1:0] pipe_row [CALC_LAT];
  logic [CW-1:0] pipe_col [CALC_LAT];
`ifdef CONV_SEQ_FILT_DEFER_EN
  logic          filt_pend;
`endif

  logic accept;
  logic last_out;

  assign accept   = bus.in_valid && (state == LOAD);
  // The bottom-right window is always the final result of a frame.
  assign last_out = pipe_vld[CALC_LAT-1] &&
                    (pipe_row[CALC_LAT-1] == LAST_WIN) &&
                    (pipe_col[CALC_LAT-1] == LAST_WIN);

  assign bus.in_ready   = (state == LOAD);
  assign bus.wr_en      = accept;
  assign bus.wr_row     = row;
  assign bus.wr_col     = col;
  assign bus.calc_start = calc_start_q;
  assign bus.calc_row   = calc_row_q;
  assign bus.calc_col   = calc_col_q;
  assign bus.out_valid  = pipe_vld[CALC_LAT-1];
  assign bus.out_row    = pipe_row[CALC_LAT-1];
  assign bus.out_col    = pipe_col[CALC_LAT-1];
  assign bus.frame_done = (state == DONE);
  assign bus.busy       = (state != IDLE);
  assign bus.filt_load  = filt_load_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      row          <= '0;
      col          <= '0;
      calc_start_q <= 1'b0;
      calc_row_q   <= '0;
      calc_col_q   <= '0;
      filt_load_q  <= 1'b0;
      for (int i = 0; i < CALC_LAT; i++) begin
        pipe_vld[i] <= 1'b0;
        pipe_row[i] <= '0;
        pipe_col[i] <= '0;
      end
`ifdef CONV_SEQ_FILT_DEFER_EN
      filt_pend    <= 1'b0;
`endif
    end else begin
      calc_start_q <= 1'b0;
      filt_load_q  <= 1'b0;

      pipe_vld[0] <= calc_start_q;
      pipe_row[0] <= calc_row_q;
      pipe_col[0] <= calc_col_q;
      for (int i = 1; i < CALC_LAT; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
        pipe_row[i] <= pipe_row[i-1];
        pipe_col[i] <= pipe_col[i-1];
      end

      case (state)
        IDLE: begin
          filt_load_q <= bus.filt_req;
          if (bus.start) begin
            state <= LOAD;
            row   <= '0;
            col   <= '0;
          end
        end
        LOAD: begin
          if (accept) begin
            // A 3x3 window completes once its bottom-right pixel arrives.
            if ((row >= TWO) && (col >= TWO)) begin
              calc_start_q <= 1'b1;
              calc_row_q   <= row - TWO;
              calc_col_q   <= col - TWO;
            end
            if (col == LAST) begin
              col <= '0;
              if (row == LAST) begin
                row   <= '0;
                state <= DRAIN;
              end else begin
                row <= row + ONE;
              end
            end else begin
              col <= col + ONE;
            end
          end
`ifdef CONV_SEQ_FILT_DEFER_EN
          if (bus.filt_req) filt_pend <= 1'b1;
`endif
        end
        DRAIN: begin
          if (last_out) state <= DONE;
`ifdef CONV_SEQ_FILT_DEFER_EN
          if (bus.filt_req) filt_pend <= 1'b1;
`endif
        end
        DONE: begin
          state <= IDLE;
`ifdef CONV_SEQ_FILT_DEFER_EN
          // Fires in the first IDLE cycle; a request in DONE merges in.
          filt_load_q <= filt_pend || bus.filt_req;
          filt_pend   <= 1'b0;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/conv_frame_sequencer.md
CONV_FRAME_SEQUENCER -- requirements
Module: conv_frame_sequencer

Interface
REQ-001 The block SHALL have parameter IMG_SIZE, default 3, meaning square frame edge in pixels; legal values are 3 or more.
REQ-002 The block SHALL have parameter CALC_LAT, default 2, meaning fixed datapath latency in cycles from calc_start to result; legal values are 1 or more.
REQ-003 The block SHALL define CW as $clog2(IMG_SIZE), minimum 1, as the width of every coordinate port.
REQ-004 The block SHALL have ports, clock and reset first:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  frame start request.
- in_valid  in  1  RGB pixel present.
- in_ready  out  1  pixel accepted when high together with in_valid.
- wr_en  out  1  write strobe to datapath pixel buffers.
- wr_row / wr_col  out  CW  write address.
- calc_start  out  1  one-cycle strobe that launches one 3x3 window.
- calc_row / calc_col  out  CW  output coordinate of the launched window.
- out_valid  out  1  datapath result for out_row/out_col is valid this cycle.
- out_row / out_col  out  CW  result coordinate.
- frame_done  out  1  one-cycle end-of-frame pulse.
- busy  out  1  high in any state other than IDLE.
- filt_req  in  1  filter-load request.
- filt_load  out  1  one-cycle strobe that tells the datapath to capture its FILTER input.

Function
REQ-005 The FSM SHALL have the states IDLE, LOAD, DRAIN and DONE, with transitions:
- IDLE->LOAD on start.
- LOAD->DRAIN on acceptance of pixel (IMG_SIZE-1, IMG_SIZE-1).
- DRAIN->DONE on the cycle the last out_valid is issued.
- DONE->IDLE unconditionally after one cycle.
REQ-006 The FSM SHALL ignore start in any state other than IDLE.
REQ-007 in_ready SHALL be high only in LOAD, and wr_en SHALL equal in_valid AND in_ready combinationally.
REQ-008 wr_row and wr_col SHALL show the current raster counters, which clear on IDLE->LOAD.
- On each acceptance, col increments.
- When col wraps from IMG_SIZE-1 to 0, row increments.
- Gaps in in_valid SHALL hold both counters.
REQ-009 One cycle after accepting pixel (r,c) with r>=2 and c>=2, calc_start SHALL pulse high, registered, with calc_row=r-2 and calc_col=c-2; no other pixel SHALL produce calc_start.
REQ-010 out_valid SHALL assert exactly CALC_LAT cycles after each calc_start, with out_row/out_col equal to that calc_start's coordinates.
- The tracking pipeline SHALL be a CALC_LAT-deep shift register.
- Back-to-back calc_starts SHALL give back-to-back out_valids.
REQ-011 Each frame SHALL produce exactly (IMG_SIZE-2)^2 calc_starts and (IMG_SIZE-2)^2 out_valids.
REQ-012 frame_done SHALL be high only in DONE.
REQ-013 filt_req SHALL be honoured in IDLE by pulsing filt_load on the following cycle; a filt_req and a start in the same IDLE cycle SHALL both be honoured.

Reset
REQ-014 While rst_n is low, asynchronously:
- State SHALL be IDLE.
- The row and col counters and the latency pipe SHALL be 0.
- in_ready, wr_en, calc_start, out_valid, frame_done, busy and filt_load SHALL be 0.
- All coordinate outputs SHALL be 0.
REQ-015 Reset asserted mid-frame SHALL discard in-flight windows, and no out_valid or frame_done SHALL follow its release.

Configuration
REQ-016 Macro CONV_SEQ_FILT_DEFER_EN SHALL control filter requests made outside IDLE.
- Defined: a filt_req seen in LOAD, DRAIN or DONE SHALL set a pending flag, and filt_load SHALL pulse on the first IDLE cycle after the frame. Several requests SHALL merge into one pulse, and reset SHALL clear the flag.
- Undefined: filt_req outside IDLE SHALL be dropped, and filt_load SHALL pulse only for requests made in IDLE.

Verification
REQ-017 The bench SHALL cover these scenarios:
- IMG_SIZE=3, CALC_LAT=2, start then 9 back-to-back pixels -> one calc_start (0,0) the cycle after the 9th acceptance; out_valid (0,0) 2 cycles later, in that same cycle DRAIN->DONE; frame_done the next cycle; busy low the cycle after.
- IMG_SIZE=4, CALC_LAT=2, 16 pixels -> calc_start at (0,0), (0,1), (1,0), (1,1) after pixels 11, 12, 15, 16; out_valids 2 cycles after each; frame_done once.
- IMG_SIZE=4, in_valid low every other cycle -> counters hold during gaps; same 4 coordinates in order; frame_done after the 4th out_valid.
- Reset pulse after pixel 10 of a 4x4 frame -> all outputs 0; no out_valid after release; a new start gives a full, correct frame.
- filt_req during LOAD -> with CONV_SEQ_FILT_DEFER_EN, a single filt_load the first IDLE cycle after frame_done; without it, no filt_load.
- start held high during LOAD and DRAIN -> no restart; counters and out_valid sequence unaffected.
